// File: rtl/pwd_pkg.sv
// Shared types and defaults for the password lock controller.
package pwd_pkg;

  localparam int DIGITS_DEF = 4;
  localparam int DW_DEF     = 2;
  localparam logic [7:0] DEFAULT_PWD_DEF = 8'hE4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_OPEN,
    S_FAIL,
    S_LOCKOUT,
    S_PROG
  } state_t;

endpackage

// File: rtl/pwd_timer.sv
// Loadable down-counter that holds at zero; shared by the unlock and lockout windows.
module pwd_timer #(
  parameter int TW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          zero
);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - TW'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pwd_lock_ctrl.sv
// Password entry sequencer: digit collection, verdict, unlock/lockout windows.
// Password reprogramming from OPEN is built only when PWD_PROGRAM_EN is defined.
module pwd_lock_ctrl
  import pwd_pkg::*;
#(
  parameter int DIGITS        = DIGITS_DEF,
  parameter int DW            = DW_DEF,
  parameter logic [DIGITS*DW-1:0] DEFAULT_PWD = (DIGITS*DW)'(DEFAULT_PWD_DEF),
  parameter int MAX_FAIL      = 3,
  parameter int UNLOCK_CYCLES = 500,
  parameter int LOCK_CYCLES   = 1000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DW-1:0]                   key_val,
  input  logic                            key_press,
  input  logic                            clear,
  input  logic                            prog,
  output logic                            unlocked,
  output logic                            err,
  output logic                            locked_out,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
  output logic [$clog2(DIGITS+1)-1:0]     digit_cnt
);

  localparam int CW = $clog2(DIGITS+1);
  localparam int FW = $clog2(MAX_FAIL+1);
  localparam int TW = $clog2(LOCK_CYCLES > UNLOCK_CYCLES ? LOCK_CYCLES : UNLOCK_CYCLES);

  state_t state, state_n;
  logic [CW-1:0] dcnt_n;
  logic [FW-1:0] fcnt_n;
  logic          mism, mism_n;
  logic          tmr_load, tmr_zero;
  logic [TW-1:0] tmr_val;
  logic [DIGITS-1:0][DW-1:0] pwd;
  logic [DW-1:0] exp_dig;
  logic          last_key;

  // Stored digit selected by the running digit count
  always_comb begin
    exp_dig = '0;
    for (int i = 0; i < DIGITS; i++)
      if (digit_cnt == CW'(i)) exp_dig = pwd[i];
  end

  assign last_key = (digit_cnt == CW'(DIGITS-1));

`ifdef PWD_PROGRAM_EN
  logic [DIGITS-1:0][DW-1:0] shadow, shadow_n;
  logic pwd_wr, shadow_wr;

  always_comb begin
    shadow_n = shadow;
    for (int i = 0; i < DIGITS; i++)
      if (digit_cnt == CW'(i)) shadow_n[i] = key_val;
  end

  // New password lands in one write so an aborted PROG never leaves a partial value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwd    <= DEFAULT_PWD;
      shadow <= '0;
    end else begin
      if (shadow_wr) shadow <= shadow_n;
      if (pwd_wr)    pwd    <= shadow_n;
    end
  end
`else
  logic unused_prog;
  assign unused_prog = prog;
  assign pwd = DEFAULT_PWD;
`endif

  always_comb begin
    state_n  = state;
    dcnt_n   = digit_cnt;
    mism_n   = mism;
    fcnt_n   = fail_cnt;
    tmr_load = 1'b0;
    tmr_val  = '0;
`ifdef PWD_PROGRAM_EN
    pwd_wr    = 1'b0;
    shadow_wr = 1'b0;
`endif
    unique case (state)
      S_IDLE, S_ENTRY: begin
        if (clear) begin
          dcnt_n  = '0;
          mism_n  = 1'b0;
          state_n = S_IDLE;
        end else if (key_press) begin
          // Sticky mismatch: the verdict waits for all digits
          mism_n  = mism | (key_val != exp_dig);
          dcnt_n  = digit_cnt + CW'(1);
          state_n = last_key ? S_CHECK : S_ENTRY;
        end
      end
      S_CHECK: begin
        dcnt_n = '0;
        mism_n = 1'b0;
        if (!mism) begin
          state_n  = S_OPEN;
          fcnt_n   = '0;
          tmr_load = 1'b1;
          tmr_val  = TW'(UNLOCK_CYCLES-1);
        end else begin
          state_n = S_FAIL;
          if (fail_cnt < FW'(MAX_FAIL)) fcnt_n = fail_cnt + FW'(1);
        end
      end
      S_OPEN: begin
        if (clear)          state_n = S_IDLE;
`ifdef PWD_PROGRAM_EN
        else if (prog)      state_n = S_PROG;
`endif
        else if (tmr_zero)  state_n = S_IDLE;
      end
      S_FAIL: begin
        if (fail_cnt == FW'(MAX_FAIL)) begin
          state_n  = S_LOCKOUT;
          tmr_load = 1'b1;
          tmr_val  = TW'(LOCK_CYCLES-1);
        end else begin
          state_n = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (tmr_zero) begin
          state_n = S_IDLE;
          fcnt_n  = '0;
        end
      end
`ifdef PWD_PROGRAM_EN
      S_PROG: begin
        if (clear) begin
          dcnt_n  = '0;
          state_n = S_IDLE;
        end else if (key_press) begin
          shadow_wr = 1'b1;
          if (last_key) begin
            pwd_wr  = 1'b1;
            dcnt_n  = '0;
            state_n = S_IDLE;
          end else begin
            dcnt_n = digit_cnt + CW'(1);
          end
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      digit_cnt  <= '0;
      fail_cnt   <= '0;
      mism       <= 1'b0;
      unlocked   <= 1'b0;
      err        <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state      <= state_n;
      digit_cnt  <= dcnt_n;
      fail_cnt   <= fcnt_n;
      mism       <= mism_n;
      unlocked   <= (state_n == S_OPEN);
      err        <= (state_n == S_FAIL);
      locked_out <= (state_n == S_LOCKOUT);
    end
  end

  pwd_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

endmodule

// File: tb/tb_pwd_lock_ctrl.sv
// Directed bench for pwd_lock_ctrl; the reprogramming test runs when PWD_PROGRAM_EN is defined.
module tb_pwd_lock_ctrl;

  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] key_val;
  logic          key_press, clear, prog;
  logic          unlocked, err, locked_out;
  logic [1:0]    fail_cnt;
  logic [2:0]    digit_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pwd_lock_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_val    (key_val),
    .key_press  (key_press),
    .clear      (clear),
    .prog       (prog),
    .unlocked   (unlocked),
    .err        (err),
    .locked_out (locked_out),
    .fail_cnt   (fail_cnt),
    .digit_cnt  (digit_cnt)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int k);
    key_val   = DW'(k);
    key_press = 1'b1;
    step();
    key_press = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic entry(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  // Wrong entry ending back in IDLE (through CHECK and FAIL), no lockout expected
  task automatic bad_entry(input int exp_fail);
    entry(3, 1, 2, 3);
    step();
    chk("bad_err", int'(err), 1);
    chk("bad_fail_cnt", int'(fail_cnt), exp_fail);
    step();
  endtask

  initial begin
    int  n;
    logic err_seen;

    rst_n = 1'b0; key_val = '0; key_press = 0; clear = 0; prog = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_unlocked", int'(unlocked), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_locked", int'(locked_out), 0);
    chk("rst_fail_cnt", int'(fail_cnt), 0);
    chk("rst_digit_cnt", int'(digit_cnt), 0);
    rst_n = 1'b1;
    step();

    // 1: correct entry, 500-cycle unlock window
    press(0); press(1); press(2);
    chk("t1_digit_cnt3", int'(digit_cnt), 3);
    press(3);
    chk("t1_unlock_check_cycle", int'(unlocked), 0);
    step();
    chk("t1_unlocked", int'(unlocked), 1);
    n = 0; err_seen = 0;
    while (unlocked && n < 600) begin
      err_seen |= err;
      n++;
      step();
    end
    chk("t1_open_cycles", n, 500);
    chk("t1_no_err", int'(err_seen), 0);
    chk("t1_idle_digit_cnt", int'(digit_cnt), 0);

    // 2: wrong first digit, verdict only after the 4th key
    press(3); press(1); press(2);
    chk("t2_digit_cnt3", int'(digit_cnt), 3);
    chk("t2_no_early_err", int'(err), 0);
    press(3);
    step();
    chk("t2_err", int'(err), 1);
    chk("t2_fail_cnt", int'(fail_cnt), 1);
    chk("t2_unlocked", int'(unlocked), 0);
    step();
    chk("t2_err_pulse", int'(err), 0);

    // 3: two more failures -> lockout, keys ignored during it
    bad_entry(2);
    entry(3, 1, 2, 3);
    step();
    chk("t3_err3", int'(err), 1);
    chk("t3_fail_cnt3", int'(fail_cnt), 3);
    step();
    chk("t3_locked", int'(locked_out), 1);
    n = 0;
    while (locked_out && n < 1200) begin
      key_val   = '0;
      key_press = (n % 50 == 5);
      clear     = (n % 50 == 7);
      if (n == 100) chk("t3_keys_ignored", int'(digit_cnt), 0);
      n++;
      step();
    end
    key_press = 0; clear = 0;
    chk("t3_lock_cycles", n, 1000);
    chk("t3_fail_cnt_cleared", int'(fail_cnt), 0);
    chk("t3_digit_cnt", int'(digit_cnt), 0);

    // 4: success clears the failure count
    bad_entry(1);
    bad_entry(2);
    entry(0, 1, 2, 3);
    step();
    chk("t4_unlocked", int'(unlocked), 1);
    chk("t4_fail_cnt0", int'(fail_cnt), 0);
    pulse_clear();
    chk("t4_relock", int'(unlocked), 0);

    // 5: clear collides with a key press mid-entry
    bad_entry(1);
    press(0); press(1);
    chk("t5_digit_cnt2", int'(digit_cnt), 2);
    key_val = 2'd2; key_press = 1; clear = 1;
    step();
    key_press = 0; clear = 0;
    chk("t5_digit_cnt0", int'(digit_cnt), 0);
    chk("t5_fail_cnt", int'(fail_cnt), 1);
    step();
    chk("t5_no_err", int'(err), 0);
    entry(0, 1, 2, 3);
    step();
    chk("t5_unlocked", int'(unlocked), 1);
    pulse_clear();

`ifdef PWD_PROGRAM_EN
    // 6: reprogram to 3,3,3,3, then reset mid-PROG restores the default
    entry(0, 1, 2, 3);
    step();
    chk("t6_open", int'(unlocked), 1);
    prog = 1; step(); prog = 0;
    chk("t6_prog_relock", int'(unlocked), 0);
    press(3); press(3);
    chk("t6_prog_digit_cnt", int'(digit_cnt), 2);
    press(3); press(3);
    chk("t6_prog_done_cnt", int'(digit_cnt), 0);
    step();
    entry(0, 1, 2, 3);
    step();
    chk("t6_old_pwd_err", int'(err), 1);
    chk("t6_old_pwd_locked", int'(unlocked), 0);
    step();
    entry(3, 3, 3, 3);
    step();
    chk("t6_new_pwd_open", int'(unlocked), 1);
    prog = 1; step(); prog = 0;
    press(1); press(1);
    rst_n = 0;
    #2;
    chk("t6_rst_digit_cnt", int'(digit_cnt), 0);
    rst_n = 1;
    step();
    entry(0, 1, 2, 3);
    step();
    chk("t6_default_restored", int'(unlocked), 1);
    chk("t6_fail_cnt", int'(fail_cnt), 0);
`else
    // 6: prog is ignored without the reprogramming option
    entry(0, 1, 2, 3);
    step();
    chk("t6_open", int'(unlocked), 1);
    prog = 1; step(); prog = 0;
    chk("t6_prog_ignored", int'(unlocked), 1);
    press(3); press(3); press(3); press(3);
    chk("t6_keys_ignored", int'(digit_cnt), 0);
    chk("t6_still_open", int'(unlocked), 1);
    pulse_clear();
    entry(3, 3, 3, 3);
    step();
    chk("t6_3333_fails", int'(err), 1);
    step();
    entry(0, 1, 2, 3);
    step();
    chk("t6_default_pwd", int'(unlocked), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
